// File: rtl/int_regfile_write_arbiter.sv
// Purpose: shares NUM_PORTS register-file write ports among NUM_REQ lanes, each with a DEPTH-entry writeback FIFO.
// Latency: at least 1 cycle from request to wp_we (no same-cycle bypass); grants are combinational from FIFO heads.
// Backpressure: req_ready[i] drops while lane i is full; stall blocks grants only, not enqueue or dead-head pops.
// Optional: define RF_WRITE_ARB_PERF_COUNTER_EN to build the saturating port-conflict counter.
module int_regfile_write_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int NUM_PORTS     = 2,
  parameter int DEPTH         = 2,
  parameter int REG_NUM_WIDTH = 7,
  parameter int DATA_WIDTH    = 32,
  parameter int AL_PTR_WIDTH  = 6,
  localparam int SRC_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               stall,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ*REG_NUM_WIDTH-1:0]   req_reg_num,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_data,
  input  logic [NUM_REQ*AL_PTR_WIDTH-1:0]    req_al_ptr,
  input  logic                               flush_valid,
  input  logic [AL_PTR_WIDTH-1:0]            flush_head_ptr,
  input  logic [AL_PTR_WIDTH-1:0]            flush_tail_ptr,
  output logic [NUM_PORTS-1:0]               wp_we,
  output logic [NUM_PORTS*REG_NUM_WIDTH-1:0] wp_reg_num,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]    wp_data,
  output logic [NUM_PORTS*SRC_W-1:0]         wp_src,
  output logic [NUM_REQ-1:0]                 pending,
  output logic [31:0]                        perf_conflict_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Per-lane FIFO state. An entry is live only while it is stored and not flushed;
  // popping always clears the live bit so pending can be a plain OR over live bits.
  logic [CNT_W-1:0]         r_count  [NUM_REQ];
  logic [PTR_W-1:0]         r_rd_ptr [NUM_REQ];
  logic [PTR_W-1:0]         r_wr_ptr [NUM_REQ];
  logic [DEPTH-1:0]         r_live   [NUM_REQ];
  logic [REG_NUM_WIDTH-1:0] r_reg_num[NUM_REQ][DEPTH];
  logic [DATA_WIDTH-1:0]    r_data   [NUM_REQ][DEPTH];
  logic [AL_PTR_WIDTH-1:0]  r_al_ptr [NUM_REQ][DEPTH];
  logic [SRC_W-1:0]         r_rr_ptr;

  logic [NUM_REQ-1:0] w_head_live;
  logic [NUM_REQ-1:0] w_head_flush;
  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_dead_pop;
  logic [NUM_REQ-1:0] w_enq;
  logic [NUM_REQ-1:0] w_enq_live;
  logic [NUM_REQ-1:0] w_grant;
  logic [NUM_REQ-1:0] w_pop;
  logic               w_any_grant;
  logic [SRC_W-1:0]   w_last_lane;

  // Active-list range test; head == tail is an empty range, head > tail wraps.
  function automatic logic in_range(input logic [AL_PTR_WIDTH-1:0] p,
                                    input logic [AL_PTR_WIDTH-1:0] head,
                                    input logic [AL_PTR_WIDTH-1:0] tail);
    if (head <= tail) return (p >= head) && (p < tail);
    else              return (p >= head) || (p < tail);
  endfunction

  // Per-lane head status, enqueue handshake and flush classification.
  always_comb begin
    req_ready    = '0;
    pending      = '0;
    w_head_live  = '0;
    w_head_flush = '0;
    w_elig       = '0;
    w_dead_pop   = '0;
    w_enq        = '0;
    w_enq_live   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i]    = (r_count[i] < CNT_W'(DEPTH));
      pending[i]      = |r_live[i];
      w_head_live[i]  = r_live[i][r_rd_ptr[i]];
      w_head_flush[i] = flush_valid &&
                        in_range(r_al_ptr[i][r_rd_ptr[i]], flush_head_ptr, flush_tail_ptr);
      // Gating with rst keeps the reset cycle itself free of writes.
      w_elig[i]       = w_head_live[i] && !w_head_flush[i] && !stall && !rst;
      w_dead_pop[i]   = (r_count[i] != '0) && !w_head_live[i];
      w_enq[i]        = req_valid[i] && req_ready[i];
      w_enq_live[i]   = !(flush_valid &&
                          in_range(req_al_ptr[i*AL_PTR_WIDTH +: AL_PTR_WIDTH],
                                   flush_head_ptr, flush_tail_ptr));
    end
  end

  // Round-robin scan from r_rr_ptr; the k-th eligible lane found drives port k.
  always_comb begin
    int               n_grant;
    int               lane;
    logic [SRC_W-1:0] lane_idx;
    n_grant     = 0;
    lane        = 0;
    lane_idx    = '0;
    w_grant     = '0;
    w_any_grant = 1'b0;
    w_last_lane = '0;
    wp_we       = '0;
    wp_reg_num  = '0;
    wp_data     = '0;
    wp_src      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      lane     = (int'(r_rr_ptr) + k) % NUM_REQ;
      lane_idx = SRC_W'(lane);
      if (w_elig[lane_idx] && (n_grant < NUM_PORTS)) begin
        w_grant[lane_idx] = 1'b1;
        w_any_grant       = 1'b1;
        w_last_lane       = lane_idx;
        for (int p = 0; p < NUM_PORTS; p++) begin
          if (p == n_grant) begin
            wp_we[p]                                     = 1'b1;
            wp_reg_num[p*REG_NUM_WIDTH +: REG_NUM_WIDTH] = r_reg_num[lane_idx][r_rd_ptr[lane_idx]];
            wp_data[p*DATA_WIDTH +: DATA_WIDTH]          = r_data[lane_idx][r_rd_ptr[lane_idx]];
            wp_src[p*SRC_W +: SRC_W]                     = lane_idx;
          end
        end
        n_grant = n_grant + 1;
      end
    end
  end

  assign w_pop = w_grant | w_dead_pop;

  // FIFO control state and round-robin pointer; flush kill, pop and enqueue all in one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r_count[i]  <= '0;
        r_rd_ptr[i] <= '0;
        r_wr_ptr[i] <= '0;
        r_live[i]   <= '0;
      end
      r_rr_ptr <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (flush_valid) begin
          for (int d = 0; d < DEPTH; d++) begin
            if (in_range(r_al_ptr[i][d], flush_head_ptr, flush_tail_ptr)) r_live[i][d] <= 1'b0;
          end
        end
        if (w_pop[i]) begin
          r_live[i][r_rd_ptr[i]] <= 1'b0;
          r_rd_ptr[i]            <= r_rd_ptr[i] + 1'b1;
        end
        // Enqueue slot never aliases the popped slot: that needs count 0 (no pop) or full (no enqueue).
        if (w_enq[i]) begin
          r_live[i][r_wr_ptr[i]] <= w_enq_live[i];
          r_wr_ptr[i]            <= r_wr_ptr[i] + 1'b1;
        end
        if (w_enq[i] && !w_pop[i])      r_count[i] <= r_count[i] + 1'b1;
        else if (!w_enq[i] && w_pop[i]) r_count[i] <= r_count[i] - 1'b1;
      end
      if (w_any_grant) begin
        r_rr_ptr <= (w_last_lane == SRC_W'(NUM_REQ - 1)) ? '0 : w_last_lane + 1'b1;
      end
    end
  end

  // Payload storage needs no reset; the live bits decide what is meaningful.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_enq[i]) begin
        r_reg_num[i][r_wr_ptr[i]] <= req_reg_num[i*REG_NUM_WIDTH +: REG_NUM_WIDTH];
        r_data[i][r_wr_ptr[i]]    <= req_data[i*DATA_WIDTH +: DATA_WIDTH];
        r_al_ptr[i][r_wr_ptr[i]]  <= req_al_ptr[i*AL_PTR_WIDTH +: AL_PTR_WIDTH];
      end
    end
  end

`ifdef RF_WRITE_ARB_PERF_COUNTER_EN
  logic [31:0] r_perf_cnt;
  logic        w_conflict;

  // A conflict cycle is one with more eligible lanes than write ports.
  always_comb begin
    int n_elig;
    n_elig = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_elig[i]) n_elig = n_elig + 1;
    end
    w_conflict = (n_elig > NUM_PORTS);
  end

  // Saturating conflict counter.
  always_ff @(posedge clk) begin
    if (rst)                                  r_perf_cnt <= '0;
    else if (w_conflict && (r_perf_cnt != '1)) r_perf_cnt <= r_perf_cnt + 32'd1;
  end

  assign perf_conflict_count = r_perf_cnt;
`else
  assign perf_conflict_count = '0;
`endif

endmodule

// File: tb/tb_int_regfile_write_arbiter.sv
// Directed bench for int_regfile_write_arbiter with default parameters.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
// A small per-lane queue checks write data ordering during the all-lane burst.
module tb_int_regfile_write_arbiter;

  localparam int NR = 4;
  localparam int NP = 2;
  localparam int RW = 7;
  localparam int DW = 32;
  localparam int AW = 6;
  localparam int SW = 2;

`ifdef RF_WRITE_ARB_PERF_COUNTER_EN
  // Cycles 1..5 of the burst each see four live heads competing for two ports.
  localparam logic [31:0] BURST_PERF = 32'd5;
`else
  localparam logic [31:0] BURST_PERF = 32'd0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              stall;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*RW-1:0]  req_reg_num;
  logic [NR*DW-1:0]  req_data;
  logic [NR*AW-1:0]  req_al_ptr;
  logic              flush_valid;
  logic [AW-1:0]     flush_head_ptr;
  logic [AW-1:0]     flush_tail_ptr;
  logic [NP-1:0]     wp_we;
  logic [NP*RW-1:0]  wp_reg_num;
  logic [NP*DW-1:0]  wp_data;
  logic [NP*SW-1:0]  wp_src;
  logic [NR-1:0]     pending;
  logic [31:0]       perf_conflict_count;

  int n_cmp;
  int n_err;

  int_regfile_write_arbiter dut (
    .clk                 (clk),
    .rst                 (rst),
    .stall               (stall),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_reg_num         (req_reg_num),
    .req_data            (req_data),
    .req_al_ptr          (req_al_ptr),
    .flush_valid         (flush_valid),
    .flush_head_ptr      (flush_head_ptr),
    .flush_tail_ptr      (flush_tail_ptr),
    .wp_we               (wp_we),
    .wp_reg_num          (wp_reg_num),
    .wp_data             (wp_data),
    .wp_src              (wp_src),
    .pending             (pending),
    .perf_conflict_count (perf_conflict_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_port(input string tag, input int p, input logic [SW-1:0] src,
                          input logic [RW-1:0] rn, input logic [DW-1:0] d);
    check({tag, ".src"}, 64'(wp_src[p*SW +: SW]), 64'(src));
    check({tag, ".reg"}, 64'(wp_reg_num[p*RW +: RW]), 64'(rn));
    check({tag, ".data"}, 64'(wp_data[p*DW +: DW]), 64'(d));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid   = '0;
    stall       = 1'b0;
    flush_valid = 1'b0;
  endtask

  task automatic drive(input int lane, input logic [RW-1:0] rn, input logic [DW-1:0] d,
                       input logic [AW-1:0] ap);
    req_valid[lane]             = 1'b1;
    req_reg_num[lane*RW +: RW]  = rn;
    req_data[lane*DW +: DW]     = d;
    req_al_ptr[lane*AW +: AW]   = ap;
  endtask

  // Burst expectations per cycle.
  logic [3:0]    b_ready [8] = '{4'hF, 4'hF, 4'h3, 4'hC, 4'h3, 4'hF, 4'hF, 4'hF};
  logic [1:0]    b_we    [8] = '{2'b00, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00};
  logic [SW-1:0] b_src0  [8] = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0};
  logic [SW-1:0] b_src1  [8] = '{2'd0, 2'd1, 2'd3, 2'd1, 2'd3, 2'd1, 2'd3, 2'd0};
  logic [DW-1:0] expq [NR][$];
  int            seq  [NR];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc;
    int n_wr;
    logic [SW-1:0] s;
    logic [DW-1:0] e;
    n_cmp = 0; n_err = 0; n_acc = 0; n_wr = 0;
    rst = 1'b1; stall = 1'b0; flush_valid = 1'b0;
    flush_head_ptr = '0; flush_tail_ptr = '0;
    req_valid = '0; req_reg_num = '0; req_data = '0; req_al_ptr = '0;

    // Reset state, sampled while rst is still high.
    tick(); tick(); #1;
    check("rst.we", 64'(wp_we), 64'h0);
    check("rst.pending", 64'(pending), 64'h0);
    check("rst.ready", 64'(req_ready), 64'hF);
    check("rst.perf", 64'(perf_conflict_count), 64'h0);

    // Single request on lane 2, written one cycle later on port 0.
    tick(); rst = 1'b0; idle(); drive(2, 7'd5, 32'hDEAD, 6'd3); #1;
    check("t1.c0.we", 64'(wp_we), 64'h0);
    check("t1.c0.ready", 64'(req_ready), 64'hF);
    tick(); idle(); #1;
    check("t1.c1.we", 64'(wp_we), 64'h1);
    chk_port("t1.c1.p0", 0, 2'd2, 7'd5, 32'hDEAD);
    chk_port("t1.c1.p1", 1, 2'd0, 7'd0, 32'h0);
    check("t1.c1.pending", 64'(pending), 64'h4);
    // rr_ptr is now 3: lanes 0,1,3 arriving together grant 3 then 0.
    tick(); idle(); drive(0, 7'd10, 32'h100, 6'd4); drive(1, 7'd11, 32'h101, 6'd5);
    drive(3, 7'd13, 32'h103, 6'd6); #1;
    check("t1.c2.we", 64'(wp_we), 64'h0);
    check("t1.c2.pending", 64'(pending), 64'h0);
    tick(); idle(); #1;
    check("t1.c3.we", 64'(wp_we), 64'h3);
    chk_port("t1.c3.p0", 0, 2'd3, 7'd13, 32'h103);
    chk_port("t1.c3.p1", 1, 2'd0, 7'd10, 32'h100);
    tick(); idle(); #1;
    check("t1.c4.we", 64'(wp_we), 64'h1);
    chk_port("t1.c4.p0", 0, 2'd1, 7'd11, 32'h101);
    chk_port("t1.c4.p1", 1, 2'd0, 7'd0, 32'h0);
    tick(); idle(); #1;
    check("t1.c5.we", 64'(wp_we), 64'h0);

    // Reset so the burst starts from rr_ptr 0 and a zero counter.
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;

    // All four lanes request for four cycles.
    for (int l = 0; l < NR; l++) seq[l] = 0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) tick();
      idle();
      if (c < 4) begin
        for (int l = 0; l < NR; l++) drive(l, 7'(l * 8 + seq[l]), 32'(l * 256 + seq[l]), 6'(l));
      end
      #1;
      check($sformatf("t2.c%0d.ready", c), 64'(req_ready), 64'(b_ready[c]));
      check($sformatf("t2.c%0d.we", c), 64'(wp_we), 64'(b_we[c]));
      check($sformatf("t2.c%0d.src0", c), 64'(wp_src[SW-1:0]), 64'(b_src0[c]));
      check($sformatf("t2.c%0d.src1", c), 64'(wp_src[2*SW-1:SW]), 64'(b_src1[c]));
      for (int p = 0; p < NP; p++) begin
        if (wp_we[p]) begin
          n_wr++;
          s = wp_src[p*SW +: SW];
          e = (expq[s].size() > 0) ? expq[s].pop_front() : 32'hFFFF_FFFF;
          check($sformatf("t2.c%0d.p%0d.data", c, p), 64'(wp_data[p*DW +: DW]), 64'(e));
        end
      end
      for (int l = 0; l < NR; l++) begin
        if (req_valid[l] && req_ready[l]) begin
          expq[l].push_back(32'(l * 256 + seq[l]));
          seq[l]++;
          n_acc++;
        end
      end
    end
    check("t2.accepted", 64'(n_acc), 64'd12);
    check("t2.written", 64'(n_wr), 64'd12);
    check("t2.pending", 64'(pending), 64'h0);
    check("t2.perf", 64'(perf_conflict_count), 64'(BURST_PERF));

    // Stored entries al_ptr 10 (lane 0) and 20 (lane 1); flush [8,12) kills only lane 0.
    tick(); idle(); stall = 1'b1; drive(0, 7'd30, 32'hA0, 6'd10); drive(1, 7'd31, 32'hA1, 6'd20); #1;
    check("t3.a.we", 64'(wp_we), 64'h0);
    tick(); idle(); stall = 1'b1; flush_valid = 1'b1; flush_head_ptr = 6'd8; flush_tail_ptr = 6'd12; #1;
    check("t3.b.we", 64'(wp_we), 64'h0);
    check("t3.b.pending", 64'(pending), 64'h3);
    tick(); idle(); #1;
    check("t3.c.we", 64'(wp_we), 64'h1);
    chk_port("t3.c.p0", 0, 2'd1, 7'd31, 32'hA1);
    check("t3.c.pending", 64'(pending), 64'h2);
    tick(); idle(); #1;
    check("t3.d.we", 64'(wp_we), 64'h0);
    check("t3.d.pending", 64'(pending), 64'h0);
    check("t3.d.ready", 64'(req_ready), 64'hF);

    // Wrapping flush [60,2) during arrival of al_ptr 63, 1, 2: only 2 survives.
    tick(); idle(); flush_valid = 1'b1; flush_head_ptr = 6'd60; flush_tail_ptr = 6'd2;
    drive(0, 7'd50, 32'hB0, 6'd63); drive(1, 7'd51, 32'hB1, 6'd1); drive(2, 7'd52, 32'hB2, 6'd2); #1;
    check("t4.e.ready", 64'(req_ready), 64'hF);
    check("t4.e.we", 64'(wp_we), 64'h0);
    tick(); idle(); #1;
    check("t4.f.we", 64'(wp_we), 64'h1);
    chk_port("t4.f.p0", 0, 2'd2, 7'd52, 32'hB2);
    check("t4.f.pending", 64'(pending), 64'h4);
    tick(); idle(); #1;
    check("t4.g.we", 64'(wp_we), 64'h0);
    check("t4.g.pending", 64'(pending), 64'h0);
    check("t4.g.ready", 64'(req_ready), 64'hF);

    // Fill lane 3 under stall, hold stall 3 more cycles, then release.
    tick(); idle(); stall = 1'b1; drive(3, 7'd60, 32'hC0, 6'd7); #1;
    check("t5.h.we", 64'(wp_we), 64'h0);
    tick(); idle(); stall = 1'b1; drive(3, 7'd61, 32'hC1, 6'd8); #1;
    check("t5.i.ready", 64'(req_ready), 64'hF);
    for (int c = 0; c < 3; c++) begin
      tick(); idle(); stall = 1'b1; drive(3, 7'd62, 32'hC2, 6'd9); #1;
      check($sformatf("t5.stall%0d.we", c), 64'(wp_we), 64'h0);
      check($sformatf("t5.stall%0d.ready", c), 64'(req_ready), 64'h7);
    end
    tick(); idle(); #1;
    check("t5.m.we", 64'(wp_we), 64'h1);
    chk_port("t5.m.p0", 0, 2'd3, 7'd60, 32'hC0);
    check("t5.m.ready", 64'(req_ready), 64'h7);
    tick(); idle(); #1;
    check("t5.n.we", 64'(wp_we), 64'h1);
    chk_port("t5.n.p0", 0, 2'd3, 7'd61, 32'hC1);
    check("t5.n.ready", 64'(req_ready), 64'hF);
    tick(); idle(); #1;
    check("t5.o.we", 64'(wp_we), 64'h0);
    check("t5.o.pending", 64'(pending), 64'h0);

    // Reset with three lanes pending.
    tick(); idle(); stall = 1'b1; drive(0, 7'd70, 32'hD0, 6'd11); drive(1, 7'd71, 32'hD1, 6'd12);
    drive(2, 7'd72, 32'hD2, 6'd13); #1;
    tick(); idle(); #1;
    check("t6.q.pending", 64'(pending), 64'h7);
    rst = 1'b1; #1;
    check("t6.q.we", 64'(wp_we), 64'h0);
    tick(); rst = 1'b0; idle(); #1;
    check("t6.r.pending", 64'(pending), 64'h0);
    check("t6.r.we", 64'(wp_we), 64'h0);
    check("t6.r.ready", 64'(req_ready), 64'hF);
    check("t6.r.perf", 64'(perf_conflict_count), 64'h0);
    tick(); idle(); #1;
    check("t6.s.we", 64'(wp_we), 64'h0);
    check("t6.s.pending", 64'(pending), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
